mips_branch_seq_ctrl: RTL

Multi-cycle sequencer that resolves MIPS conditional branches (BEQ/BNE) using the shared register file and the shared 32-bit ALU.
- Accepts one instruction plus its PC via a valid/ready handshake.
- Drives register-file read addresses and ALU operands, with ALUOp=01 (subtract) to the ALU control unit.
- Samples the ALU zero flag and produces next-PC with a one-cycle valid pulse.
- Sits between fetch/decode and the PC register.
- Non-branch opcodes get PC+4 without touching the ALU.

---
 rtl/mips_branch_seq_ctrl_pkg.sv | 25 ++
 rtl/mips_branch_target.sv | 20 ++
 rtl/mips_branch_seq_ctrl.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/mips_branch_seq_ctrl_pkg.sv
// Shared definitions for the branch sequencer: opcodes, ALUOp codes, FSM states.
package mips_branch_seq_ctrl_pkg;

  localparam logic [5:0] OPC_BEQ = 6'd4;
  localparam logic [5:0] OPC_BNE = 6'd5;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_EXEC,
    ST_RESOLVE
  } state_e;

  // Kind of the instruction currently being resolved.
  typedef enum logic [1:0] {
    BR_NONE,
    BR_BEQ,
    BR_BNE
  } br_kind_e;

endpackage

// File: rtl/mips_branch_target.sv
// Combinational branch-target arithmetic: pc+4 and pc+4 + (sext(imm) << 2).
module mips_branch_target
  import mips_branch_seq_ctrl_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [15:0] imm,
  output logic [31:0] pc_plus4,
  output logic [31:0] br_target
);

  logic signed [31:0] offset;

  // Sign-extend the word offset to a byte offset; all sums wrap modulo 2^32.
  always_comb begin
    offset    = {{14{imm[15]}}, imm, 2'b00};
    pc_plus4  = pc + 32'd4;
    br_target = pc_plus4 + $unsigned(offset);
  end

endmodule

// File: rtl/mips_branch_seq_ctrl.sv
// Multi-cycle BEQ/BNE resolver using the shared register file and ALU.
module mips_branch_seq_ctrl
  import mips_branch_seq_ctrl_pkg::*;
#(
  parameter int         CNT_W  = 16,
  parameter logic [5:0] BEQ_OP = OPC_BEQ,
  parameter logic [5:0] BNE_OP = OPC_BNE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [31:0]      instr,
  input  logic [31:0]      pc,
  output logic [4:0]       rf_rs_addr,
  output logic [4:0]       rf_rt_addr,
  input  logic [31:0]      rf_rs_data,
  input  logic [31:0]      rf_rt_data,
  output logic [1:0]       alu_op,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  input  logic             alu_zero,
  output logic [31:0]      npc,
  output logic             taken,
  output logic             npc_valid,
  output logic [CNT_W-1:0] taken_count
);

  state_e           state_q, state_d;
  br_kind_e         kind_q, kind_d;
  logic [31:0]      pc_q, pc_d;
  logic [15:0]      imm_q, imm_d;
  logic             zero_q, zero_d;
  logic [4:0]       rs_addr_q, rs_addr_d;
  logic [4:0]       rt_addr_q, rt_addr_d;
  logic [31:0]      alu_a_q, alu_a_d;
  logic [31:0]      alu_b_q, alu_b_d;
  logic [31:0]      npc_q, npc_d;
  logic             taken_q, taken_d;
  logic             npc_valid_q, npc_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             br_taken;
  logic [5:0]       opcode;
  logic [31:0]      pc_plus4;
  logic [31:0]      br_target;

  assign opcode = instr[31:26];

  mips_branch_target u_target (
    .pc        (pc_q),
    .imm       (imm_q),
    .pc_plus4  (pc_plus4),
    .br_target (br_target)
  );

  // Next-state, datapath loads and outputs for the IDLE/READ/EXEC/RESOLVE sequence.
  always_comb begin
    state_d     = state_q;
    kind_d      = kind_q;
    pc_d        = pc_q;
    imm_d       = imm_q;
    zero_d      = zero_q;
    rs_addr_d   = rs_addr_q;
    rt_addr_d   = rt_addr_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    npc_d       = npc_q;
    taken_d     = taken_q;
    npc_valid_d = 1'b0;
    cnt_d       = cnt_q;
    br_taken    = 1'b0;
    instr_ready = 1'b0;
    alu_op      = ALUOP_ADD;
    case (state_q)
      ST_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          pc_d  = pc;
          imm_d = instr[15:0];
          if (opcode == BEQ_OP || opcode == BNE_OP) begin
            kind_d    = (opcode == BEQ_OP) ? BR_BEQ : BR_BNE;
            rs_addr_d = instr[25:21];
            rt_addr_d = instr[20:16];
            state_d   = ST_READ;
          end else begin
            // Non-branches skip the register file and ALU entirely.
            kind_d  = BR_NONE;
            state_d = ST_RESOLVE;
          end
        end
      end
      ST_READ: begin
        alu_a_d = rf_rs_data;
        alu_b_d = rf_rt_data;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        alu_op  = ALUOP_SUB;
        zero_d  = alu_zero;
        state_d = ST_RESOLVE;
      end
      ST_RESOLVE: begin
        case (kind_q)
          BR_BEQ:  br_taken = zero_q;
          BR_BNE:  br_taken = !zero_q;
          default: br_taken = 1'b0;
        endcase
        taken_d     = br_taken;
        npc_d       = br_taken ? br_target : pc_plus4;
        npc_valid_d = 1'b1;
        if (br_taken && cnt_q != {CNT_W{1'b1}})
          cnt_d = cnt_q + CNT_W'(1);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and externally visible registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      rs_addr_q   <= '0;
      rt_addr_q   <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      npc_q       <= '0;
      taken_q     <= 1'b0;
      npc_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      rs_addr_q   <= rs_addr_d;
      rt_addr_q   <= rt_addr_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      npc_q       <= npc_d;
      taken_q     <= taken_d;
      npc_valid_q <= npc_valid_d;
      cnt_q       <= cnt_d;
    end
  end

  // Latched instruction fields; always written before they are consumed.
  always_ff @(posedge clk) begin
    kind_q <= kind_d;
    pc_q   <= pc_d;
    imm_q  <= imm_d;
    zero_q <= zero_d;
  end

  assign rf_rs_addr  = rs_addr_q;
  assign rf_rt_addr  = rt_addr_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign npc         = npc_q;
  assign taken       = taken_q;
  assign npc_valid   = npc_valid_q;
  assign taken_count = cnt_q;

endmodule
